// File: rtl/cla_8bit.sv
// cla_8bit: registered 8-bit two-level carry-lookahead adder.
//   {C_out, S} <= A + B + C on every rising edge of clk (1-cycle latency,
//   one add per cycle, no enable or handshake).
// Ports:
//   clk    in   1  clock, rising edge
//   rst_n  in   1  asynchronous active-low reset, clears S and C_out
//   A      in   8  operand A, unsigned
//   B      in   8  operand B, unsigned
//   C      in   1  carry-in
//   C_out  out  1  registered carry-out of bit 7
//   S      out  8  registered sum
module cla_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       C,
  output logic       C_out,
  output logic [7:0] S
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       gg0, gp0, gg1, gp1;
  logic [7:0] s_d;
  logic [7:0] s_q;
  logic       co_d;
  logic       co_q;

  assign g = A & B;
  assign p = A ^ B;

  // Group 0, bits [3:0]: flat sum-of-products from the adder carry-in.
  assign c[0] = C;
  assign c[1] = g[0] | (p[0] & C);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & C);

  assign gg0 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
  assign gp0 = p[3] & p[2] & p[1] & p[0];

  // Group 1, bits [7:4].
  assign gg1 = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5])
             | (p[7] & p[6] & p[5] & g[4]);
  assign gp1 = p[7] & p[6] & p[5] & p[4];

  // Second-level lookahead: group carries come straight from C and the
  // group generate/propagate terms, never from a rippled bit carry.
  assign c[4] = gg0 | (gp0 & C);
  assign c[8] = gg1 | (gp1 & gg0) | (gp1 & gp0 & C);

  // Group 1 internal carries use c[4] as their group carry-in.
  assign c[5] = g[4] | (p[4] & c[4]);
  assign c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
  assign c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4])
              | (p[6] & p[5] & p[4] & c[4]);

  assign s_d  = p ^ c[7:0];
  assign co_d = c[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= 8'h00;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign S     = s_q;
  assign C_out = co_q;

endmodule

// File: tb/tb_cla_8bit.sv
module tb_cla_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       C;
  logic       C_out;
  logic [7:0] S;

  int vectors    = 0;
  int miscompares = 0;
  bit model_en   = 1'b0;

  cla_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C     (C),
    .C_out (C_out),
    .S     (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer addition of the operands present at the
  // edge, or zero if reset is held; checked 1 time unit after the edge.
  always @(posedge clk) begin
    logic [8:0] exp_v;
    if (model_en) begin
      if (!rst_n) exp_v = 9'd0;
      else        exp_v = 9'(int'(A) + int'(B) + int'(C));
      #1;
      vectors++;
      if ({C_out, S} !== exp_v) begin
        miscompares++;
        $display("FAIL model: got {C_out,S}=%h expected %h", {C_out, S}, exp_v);
      end
    end
  end

  task automatic check_now(input string name, input logic [7:0] es, input logic eco);
    vectors++;
    if (S !== es || C_out !== eco) begin
      miscompares++;
      $display("FAIL %s: got S=%h C_out=%b expected S=%h C_out=%b", name, S, C_out, es, eco);
    end
  endtask

  // Drive operands at the falling edge, check the literal after the next rise.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic eco);
    @(negedge clk);
    A = a; B = b; C = ci;
    @(posedge clk);
    #1;
    check_now($sformatf("add %h+%h+%b", a, b, ci), es, eco);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t dir [15];

  initial begin
    dir[0]  = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    dir[1]  = '{8'h0A, 8'h82, 1'b0, 8'h8C, 1'b0};
    dir[2]  = '{8'h11, 8'h22, 1'b1, 8'h34, 1'b0};
    dir[3]  = '{8'h99, 8'h62, 1'b0, 8'hFB, 1'b0};
    dir[4]  = '{8'hD9, 8'h0F, 1'b0, 8'hE8, 1'b0};
    dir[5]  = '{8'd15, 8'd84, 1'b0, 8'h63, 1'b0};
    dir[6]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    dir[7]  = '{8'h01, 8'hFE, 1'b0, 8'hFF, 1'b0};
    dir[8]  = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    dir[9]  = '{8'h49, 8'hDA, 1'b1, 8'h24, 1'b1};
    dir[10] = '{8'd87, 8'hAA, 1'b0, 8'h01, 1'b1};
    dir[11] = '{8'd212, 8'hAA, 1'b0, 8'h7E, 1'b1};
    dir[12] = '{8'h55, 8'd199, 1'b0, 8'h1C, 1'b1};
    dir[13] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    dir[14] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    rst_n = 1'b0;
    A = 8'hFF; B = 8'hFF; C = 1'b1;
    #2;
    model_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset hold", 8'h00, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors back-to-back, one per edge.
    foreach (dir[i]) apply(dir[i].a, dir[i].b, dir[i].ci, dir[i].s, dir[i].co);

    // Inputs wiggling between edges must not disturb the registered outputs.
    apply(8'h49, 8'hDA, 1'b1, 8'h24, 1'b1);
    #2;
    A = 8'h00; B = 8'h00; C = 1'b0;
    #1;
    check_now("no glitch", 8'h24, 1'b1);
    A = 8'h33; B = 8'h44; C = 1'b1;
    #1;
    check_now("no glitch 2", 8'h24, 1'b1);

    // Asynchronous reset mid-cycle after a nonzero result.
    apply(8'h99, 8'h62, 1'b0, 8'hFB, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async reset", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_now("reset held", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Random vectors, checked by the model process every edge.
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      A = 8'($urandom);
      B = 8'($urandom);
      C = 1'($urandom);
    end
    @(posedge clk);
    #3;
    model_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cla_8bit.md
# cla_8bit

Registered 8-bit carry-lookahead adder: S = A + B + C, with carry-out C_out. It serves as the arithmetic leaf for datapaths that need a fast 8-bit add with a clean registered boundary. Carry computation uses two-level lookahead, not ripple. Results appear one clock after operands are sampled.

## Interface
- No parameters; width fixed at 8 bits.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- C  input  1  carry-in.
- C_out  output  1  registered carry-out of bit 7.
- S  output  8  registered sum bits [7:0].

## Operation
- Bit level, for i in 0..7: g[i] = A[i] & B[i] and p[i] = A[i] ^ B[i].
- Two 4-bit lookahead groups: bits [3:0] and [7:4].
- Inside each group, carries are flat sum-of-products of g, p and the group carry-in. No chained carry between bits.
  - c1 = g0 | p0·cin
  - c2 = g1 | p1·g0 | p1·p0·cin
  - c3 and c4 follow the same pattern.
- Each group also produces group generate GG = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 and group propagate GP = p3·p2·p1·p0.
- Second-level lookahead unit:
  - c4 = GG0 | GP0·C
  - c8 = GG1 | GP1·GG0 | GP1·GP0·C
- Sum: s[i] = p[i] ^ c[i], with c[0] = C.
- Result is {c8, s[7:0]}, which must equal the 9-bit value A + B + C for all 2^17 input combinations.
- The adder path is purely combinational. Only S and C_out are registered.
- There is no enable: every rising edge captures a new result.
- Arithmetic is unsigned modulo 256 with carry-out. No overflow flag and no signed interpretation.

## Timing
- On the rising edge of clk: S <= s[7:0] and C_out <= c8, computed from the A, B and C present just before the edge.
- Latency is 1 cycle. Throughput is one add per cycle, with no handshake.
- Reset:
  - rst_n low forces S = 8'h00 and C_out = 0 immediately, independent of clk.
  - Outputs stay cleared while rst_n is low.
  - The first capture happens at the first rising edge after rst_n deasserts.
  - Deasserting reset mid-stream simply resumes capture.
- Inputs may change at any time. Only values meeting setup at the edge matter.
- Operands that change between edges produce no output glitch, because outputs are registers.
- Combinational depth from A/B/C to the register D inputs: XOR, two-level AND-OR (group), two-level AND-OR (second level), XOR. Carry delay must not grow linearly with bit position.

## Test plan
- Reset: hold rst_n=0 with A=8'hFF, B=8'hFF, C=1 and toggle clk. Then S=8'h00 and C_out=0. Assert rst_n low asynchronously mid-cycle after a nonzero result: outputs clear without waiting for a clock edge.
- Basic adds, one edge each:
  - 8'h01+8'h02+0 -> S=8'h03, C_out=0
  - 8'h0A+8'h82+0 -> 8'h8C, 0
  - 8'h11+8'h22+1 -> 8'h34, 0
  - 8'h99+8'h62+0 -> 8'hFB, 0
  - 8'hD9+8'h0F+0 -> 8'hE8, 0
  - 15+84 -> 8'h63, 0
- Full propagate chain:
  - 8'h00+8'hFF+1 -> S=8'h00, C_out=1
  - 8'h01+8'hFE+0 -> 8'hFF, 0
  - 8'h55+8'hAA+0 -> 8'hFF, 0
  - These exercise GP0·GP1·C.
- Carry-out cases:
  - 8'h49+8'hDA+1 -> 8'h24, 1
  - 87+8'hAA -> 8'h01, 1
  - 212+8'hAA -> 8'h7E, 1
  - 8'h55+199 -> 8'h1C, 1
  - 8'hFF+8'hFF+1 -> 8'hFF, 1
- Latency and pipelining: change operands every cycle (the sequence above back-to-back). Each result appears exactly one edge after its operands, with no stale or skipped values. Changing inputs between edges does not alter the outputs.
- Exhaustive/random: compare {C_out,S} against A+B+C (delayed one cycle) for all 131072 input combinations, or at least 10k random vectors, with zero mismatches.
